pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer: the consumer of the comparator's jump flag. Issues fetch
//  addresses, waits for the decoded instruction, then picks the next PC: sequential,
//  conditional/unconditional jump, call (push return address) or return (pop).
//  Sits between the instruction memory, the decoder and the comparator.
//  Owns a small return-address stack and halts on stack misuse.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  RAS_DEPTH  4         return-address stack entries (power of 2, >=2)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  instr_valid  in   1   decoder: instruction for current pc is decoded (one-cycle pulse)
//  is_jmp       in   1   decoded op: unconditional jump to target
//  is_branch    in   1   decoded op: conditional jump, taken when jump=1
//  is_call      in   1   decoded op: push pc+1, go to target
//  is_ret       in   1   decoded op: pop return address into pc
//  jump         in   1   comparator result for the current instruction
//  target       in   16  branch/call destination (absolute, from instruction N field)
//  stall        in   1   hold in EXEC; no PC update, no stack change
//  fetch_req    out  1   high in FETCH: pc is a valid fetch address
//  pc           out  16  current program counter
//  taken        out  1   one-cycle pulse: last EXEC redirected the PC
//  halted       out  1   high in HALT
//  err_code     out  2   00 none, 01 RAS overflow, 10 RAS underflow; held in HALT
// BEHAVIOUR
//  Reset (sync, any state, mid-op included): pc=RESET_PC, state=FETCH, RAS emptied
//   (count=0), taken=0, halted=0, err_code=00. fetch_req=1 in the first cycle after.
//  States: FETCH, EXEC, HALT.
//   FETCH: fetch_req=1. instr_valid=1 -> sample op flags, jump, target -> EXEC.
//          instr_valid=0 -> stay. Op flags ignored outside an instr_valid cycle.
//   EXEC: fetch_req=0. stall=1 -> stay, nothing changes. stall=0 -> resolve, -> FETCH
//          (or HALT on error). pc register updates on the EXEC->FETCH edge, so the new
//          pc is visible with fetch_req in the next cycle. Latency instr_valid->next
//          fetch_req = 2 cycles with no stall.
//   HALT: terminal; fetch_req=0, pc frozen, halted=1; only reset exits.
//  Resolution priority (multiple flags set): ret > call > jmp > branch > sequential.
//   ret:    count==0 -> HALT, err_code=10, pc unchanged; else pc<=top, count-1, taken=1.
//   call:   count==RAS_DEPTH -> HALT, err_code=01, pc unchanged;
//           else push pc+1, pc<=target, count+1, taken=1.
//   jmp:    pc<=target, taken=1.
//   branch: jump=1 -> pc<=target, taken=1; jump=0 -> pc<=pc+1, taken=0.
//   none:   pc<=pc+1, taken=0.
//  Arithmetic: pc+1 is 16-bit modulo; 16'hFFFF wraps to 16'h0000, no flag.
//  taken pulses in the cycle after the resolving EXEC, for exactly one cycle.
//  Call with target==pc is legal (self-loop); pushed value is still pc+1.
// STRUCTURE
//  Shared package: state encoding (FETCH/EXEC/HALT), err_code constants
//   (ERR_NONE/ERR_OVF/ERR_UDF), and the 16-bit address width constant.
//  Sub-module ret_addr_stack: RAS_DEPTH x 16 LIFO with push, pop, top, count, full, empty;
//   simultaneous push+pop is never issued by pc_sequencer (asserted in simulation).
//  Sequencer holds the FSM, pc register and sampled decode fields.
// TESTING
//  Reset then 3 plain instr_valid pulses -> pc 0,1,2,3; fetch_req every 2nd cycle; taken=0.
//  pc=0x0010, is_branch, jump=1, target=0x0040 -> pc=0x0040, taken pulse; jump=0 -> pc=0x0011.
//  call at 0x0005 to 0x0100, then ret -> pc 0x0100 then 0x0006; RAS count 1 then 0.
//  RAS_DEPTH=4: 5 nested calls -> 5th enters HALT, err_code=01, pc stays at 5th call addr.
//  ret with empty stack -> HALT, err_code=10; then reset -> pc=RESET_PC, err_code=00.
//  pc=0xFFFF sequential -> 0x0000; stall=1 for 3 cycles in EXEC -> pc held, then updates.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: address width, FSM
// state encodings, halt error codes and the sampled decode record.
package pc_sequencer_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UDF  = 2'b10;

  typedef struct packed {
    logic              jmp;
    logic              branch;
    logic              call;
    logic              ret;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } decode_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: DEPTH x WIDTH LIFO. Push and pop are never requested
// in the same cycle by the sequencer.
import pc_sequencer_pkg::*;

module ret_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  assign top_idx = AW'(count - 1'b1);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[AW-1:0]] <= din;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && pop));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC/HALT FSM choosing the next pc from the
// decoded op, comparator jump flag and the return-address stack.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic              is_jmp,
  input  logic              is_branch,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              stall,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              halted,
  output logic [1:0]        err_code
);

  logic [1:0]                  state;
  decode_t                     dec;
  logic [ADDR_W-1:0]           pc_inc;
  logic [ADDR_W-1:0]           pc_next;
  logic                        taken_next;
  logic                        go_halt;
  logic [1:0]                  err_next;
  logic                        ras_push;
  logic                        ras_pop;
  logic [ADDR_W-1:0]           ras_top;
  logic [$clog2(RAS_DEPTH):0]  ras_count;
  logic                        ras_full;
  logic                        ras_empty;

  assign pc_inc    = pc + 16'd1;
  assign fetch_req = (state == ST_FETCH);
  assign halted    = (state == ST_HALT);

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Resolution priority: ret > call > jmp > branch > sequential.
  always_comb begin
    pc_next    = pc;
    taken_next = 1'b0;
    go_halt    = 1'b0;
    err_next   = ERR_NONE;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (state == ST_EXEC && !stall) begin
      if (dec.ret) begin
        if (ras_empty) begin
          go_halt  = 1'b1;
          err_next = ERR_UDF;
        end else begin
          pc_next    = ras_top;
          ras_pop    = 1'b1;
          taken_next = 1'b1;
        end
      end else if (dec.call) begin
        if (ras_full) begin
          go_halt  = 1'b1;
          err_next = ERR_OVF;
        end else begin
          pc_next    = dec.target;
          ras_push   = 1'b1;
          taken_next = 1'b1;
        end
      end else if (dec.jmp || (dec.branch && dec.jump)) begin
        pc_next    = dec.target;
        taken_next = 1'b1;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      dec      <= '0;
      taken    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      taken <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            dec   <= '{jmp: is_jmp, branch: is_branch, call: is_call,
                       ret: is_ret, jump: jump, target: target};
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc       <= pc_next;
            taken    <= taken_next;
            err_code <= err_next;
            state    <= go_halt ? ST_HALT : ST_FETCH;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
